// File: rtl/align_accum.sv
// align_accum: accepts one sample per valid/ready handshake, rounds it up to
// the next multiple of 2^ALIGN by single-step increments, then adds it into a
// registered accumulator that either wraps or clamps to the largest aligned
// value. The overflow flag is sticky; clr empties the block without a pulse.
module align_accum #(
    parameter int WIDTH    = 8,
    parameter int ALIGN    = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic             busy,
    output logic             overflow
);

    // Largest accumulator value whose low ALIGN bits are zero.
    localparam logic [WIDTH-1:0] MAXAL = {{(WIDTH-ALIGN){1'b1}}, {ALIGN{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ADD   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] buffer;
    logic [WIDTH:0]   sum_p0;
    logic             aligned;
    logic             accept;

    // Wrap keeps the low WIDTH bits; saturate clamps a carried sum to MAXAL.
    function automatic logic [WIDTH-1:0] fold_sum(input logic [WIDTH:0] s);
        if (SATURATE != 0 && s[WIDTH])
            return MAXAL;
        return s[WIDTH-1:0];
    endfunction

    assign aligned = (buffer[ALIGN-1:0] == '0);
    assign accept  = in_valid && in_ready && !clr;
    assign sum_p0  = {1'b0, dout} + {1'b0, buffer};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state decode; clr returns to IDLE from anywhere and blocks acceptance.
    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept)  state_nx = ST_ALIGN;
                ST_ALIGN: if (aligned) state_nx = ST_ADD;
                ST_ADD:   state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs; in_ready is forced low while in reset.
    always_comb begin
        in_ready = (state == ST_IDLE) && reset_n;
        busy     = (state != ST_IDLE);
    end

    // Datapath: capture, increment until aligned, accumulate with wrap/clamp.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buffer    <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                dout     <= '0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept)
                            buffer <= din;
                    end
                    ST_ALIGN: begin
                        if (!aligned)
                            buffer <= buffer + WIDTH'(1);
                    end
                    ST_ADD: begin
                        dout      <= fold_sum(sum_p0);
                        out_valid <= 1'b1;
                        if (sum_p0[WIDTH])
                            overflow <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_align_accum.sv
// Testbench for align_accum: a wrapping and a saturating instance share the
// same stimulus and are compared against an arithmetic model of the
// round-up-and-accumulate behaviour.
module tb_align_accum;

    localparam int W = 8;
    localparam int A = 2;
    localparam int MOD = 1 << W;
    localparam int STEP = 1 << A;
    localparam int MAXAL = MOD - STEP;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         clr = 1'b0;

    logic         in_ready_w, out_valid_w, busy_w, overflow_w;
    logic [W-1:0] dout_w;
    logic         in_ready_s, out_valid_s, busy_s, overflow_s;
    logic [W-1:0] dout_s;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    int acc_w = 0;
    int acc_s = 0;
    bit ovf_m = 0;

    always #5 clk = ~clk;

    align_accum #(.WIDTH(W), .ALIGN(A), .SATURATE(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .din(din), .clr(clr), .dout(dout_w), .out_valid(out_valid_w),
        .busy(busy_w), .overflow(overflow_w)
    );

    align_accum #(.WIDTH(W), .ALIGN(A), .SATURATE(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .din(din), .clr(clr), .dout(dout_s), .out_valid(out_valid_s),
        .busy(busy_s), .overflow(overflow_s)
    );

    // Model: round d up to a multiple of STEP (mod 2^W), then add.
    function automatic int incr_count(input int d);
        return (STEP - (d % STEP)) % STEP;
    endfunction

    task automatic model_add(input int d);
        int r, sw, ss;
        r  = (d + incr_count(d)) % MOD;
        sw = acc_w + r;
        ss = acc_s + r;
        if (sw >= MOD) ovf_m = 1;
        acc_w = sw % MOD;
        acc_s = (ss >= MOD) ? MAXAL : ss;
    endtask

    // Starts and ends on a negedge. gap=1 also checks the cycle after the pulse.
    task automatic send(input logic [W-1:0] d, input bit gap);
        int cnt, k;
        bit seen;
        k = incr_count(int'(d));
        n_cmp++;
        if (in_ready_w !== 1'b1 || in_ready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b/%b required 1", in_ready_w, in_ready_s);
        end
        in_valid = 1'b1;
        din = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din = W'($urandom);
        model_add(int'(d));
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (out_valid_w === 1'b1 || out_valid_s === 1'b1) begin
                seen = 1;
            end else begin
                n_cmp++;
                if (busy_w !== 1'b1 || in_ready_w !== 1'b0) begin
                    n_fail++;
                    $display("FAIL send_busy: d=%h cyc=%0d busy=%b in_ready=%b required 1/0",
                             d, cnt, busy_w, in_ready_w);
                end
            end
        end
        n_cmp++;
        if (!seen || cnt != 3 + k) begin
            n_fail++;
            $display("FAIL send_latency: d=%h cycles=%0d required %0d", d, cnt, 3 + k);
        end
        n_cmp++;
        if (out_valid_w !== 1'b1 || out_valid_s !== 1'b1) begin
            n_fail++;
            $display("FAIL send_pulse: out_valid=%b/%b required 1/1", out_valid_w, out_valid_s);
        end
        n_cmp++;
        if (dout_w !== W'(acc_w) || dout_s !== W'(acc_s)) begin
            n_fail++;
            $display("FAIL send_dout: d=%h dout=%h/%h required %h/%h",
                     d, dout_w, dout_s, W'(acc_w), W'(acc_s));
        end
        n_cmp++;
        if (overflow_w !== ovf_m || overflow_s !== ovf_m) begin
            n_fail++;
            $display("FAIL send_ovf: overflow=%b/%b required %b", overflow_w, overflow_s, ovf_m);
        end
        n_cmp++;
        if (in_ready_w !== 1'b1 || busy_w !== 1'b0 || dout_w[A-1:0] !== '0 || dout_s[A-1:0] !== '0) begin
            n_fail++;
            $display("FAIL send_done: in_ready=%b busy=%b low=%b/%b required 1/0/0/0",
                     in_ready_w, busy_w, dout_w[A-1:0], dout_s[A-1:0]);
        end
        if (gap) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid_w !== 1'b0 || out_valid_s !== 1'b0) begin
                n_fail++;
                $display("FAIL send_single: out_valid=%b/%b required 0", out_valid_w, out_valid_s);
            end
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        acc_w = 0;
        acc_s = 0;
        ovf_m = 0;
        @(negedge clk);
        n_cmp++;
        if (dout_w !== '0 || dout_s !== '0 || overflow_w !== 1'b0 || busy_w !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: dout=%h/%h ovf=%b busy=%b required 0", dout_w, dout_s,
                     overflow_w, busy_w);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b1;
        din = 8'h33;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (dout_w !== '0 || dout_s !== '0 || out_valid_w !== 1'b0 || overflow_w !== 1'b0 ||
            busy_w !== 1'b0 || in_ready_w !== 1'b0 || in_ready_s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: dout=%h ov=%b ovf=%b busy=%b rdy=%b/%b required 0",
                     dout_w, out_valid_w, overflow_w, busy_w, in_ready_w, in_ready_s);
        end
        in_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready_w !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready_w);
        end
        @(negedge clk);
        n_cmp++;
        if (busy_w !== 1'b0 || dout_w !== '0 || in_ready_w !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_take: busy=%b dout=%h rdy=%b required 0/00/1",
                     busy_w, dout_w, in_ready_w);
        end
    endtask

    task automatic test_unaligned();
        send(8'h05, 1);
    endtask

    task automatic test_aligned();
        send(8'h04, 1);
    endtask

    task automatic test_wrap_sat();
        do_clear();
        send(8'hFC, 1);
        send(8'h08, 1);
        send(8'h00, 1);
    endtask

    task automatic test_clear();
        int i;
        do_clear();
        send(8'hFC, 1);
        send(8'h08, 1);
        // clr during ALIGN of 0x01
        in_valid = 1'b1;
        din = 8'h01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        do_clear();
        n_cmp++;
        if (out_valid_w !== 1'b0 || in_ready_w !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_align: out_valid=%b in_ready=%b required 0/1", out_valid_w, in_ready_w);
        end
        for (i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid_w !== 1'b0 || busy_w !== 1'b0 || dout_w !== '0) begin
                n_fail++;
                $display("FAIL clear_discard: cyc=%0d out_valid=%b busy=%b dout=%h required 0",
                         i, out_valid_w, busy_w, dout_w);
            end
        end
        // clr together with a handshake in IDLE
        clr = 1'b1;
        in_valid = 1'b1;
        din = 8'h05;
        #1;
        n_cmp++;
        if (in_ready_w !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_hs_ready: in_ready=%b required 1", in_ready_w);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        for (i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid_w !== 1'b0 || busy_w !== 1'b0 || dout_w !== '0) begin
                n_fail++;
                $display("FAIL clear_hs_taken: cyc=%0d out_valid=%b busy=%b dout=%h required 0",
                         i, out_valid_w, busy_w, dout_w);
            end
        end
    endtask

    task automatic test_reset_mid();
        send(8'h10, 1);
        in_valid = 1'b1;
        din = 8'h04;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy_w !== 1'b1 || out_valid_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pre: busy=%b out_valid=%b required 1/0", busy_w, out_valid_w);
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dout_w !== '0 || dout_s !== '0 || out_valid_w !== 1'b0 || overflow_w !== 1'b0 ||
            busy_w !== 1'b0 || in_ready_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: dout=%h/%h ov=%b ovf=%b busy=%b rdy=%b required 0",
                     dout_w, dout_s, out_valid_w, overflow_w, busy_w, in_ready_w);
        end
        reset_n = 1'b1;
        acc_w = 0;
        acc_s = 0;
        ovf_m = 0;
        @(negedge clk);
        n_cmp++;
        if (out_valid_w !== 1'b0 || dout_w !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_after: out_valid=%b dout=%h required 0", out_valid_w, dout_w);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                do_clear();
            send(W'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++)
            send(W'($urandom), 0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unaligned();
        test_aligned();
        test_wrap_sat();
        test_clear();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
